// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage scoreboard, forwarding, load-use/memwait stall and redirect flush sequencer (optional HAZARD_STATS_EN stall counter)
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IdValid,
    input  logic [2:0]       IdRs,
    input  logic [2:0]       IdRt,
    input  logic             IdUsesRs,
    input  logic             IdUsesRt,
    input  logic             IdWrEn,
    input  logic [2:0]       IdWrReg,
    input  logic             IdIsLoad,
    input  logic             Redirect,
    input  logic             MemBusy,
    output logic             Stall,
    output logic             Bubble,
    output logic             Flush,
    output logic             ForwardRs,
    output logic             ForwardRt,
    output logic [1:0]       RsFwdSrc,
    output logic [1:0]       RtFwdSrc,
    output logic [CNT_W-1:0] StallCount
);
    localparam logic [1:0] RUN = 2'd0, LDSTALL = 2'd1, FLUSH = 2'd2, MEMWAIT = 2'd3;
    logic       ex_v_q, mem_v_q, wb_v_q, ex_l_q;
    logic [2:0] ex_r_q, mem_r_q, wb_r_q;
    logic [1:0] state_q, state_d, sav_q, sav_d, cnt_q, cnt_d, eff;
    logic       lu, redir;
    // an EX load that matches a used source blocks forwarding entirely: older copies are stale
    assign RsFwdSrc = ~IdUsesRs ? 2'b00 : (ex_v_q && ex_r_q == IdRs) ? (ex_l_q ? 2'b00 : 2'b01) :
                      (mem_v_q && mem_r_q == IdRs) ? 2'b10 : (wb_v_q && wb_r_q == IdRs) ? 2'b11 : 2'b00;
    assign RtFwdSrc = ~IdUsesRt ? 2'b00 : (ex_v_q && ex_r_q == IdRt) ? (ex_l_q ? 2'b00 : 2'b01) :
                      (mem_v_q && mem_r_q == IdRt) ? 2'b10 : (wb_v_q && wb_r_q == IdRt) ? 2'b11 : 2'b00;
    assign ForwardRs = |RsFwdSrc;
    assign ForwardRt = |RtFwdSrc;
    assign lu = ~rst & IdValid & ex_v_q & ex_l_q &
                ((IdUsesRs & (ex_r_q == IdRs)) | (IdUsesRt & (ex_r_q == IdRt)));
    // MEMWAIT is transparent: once memory is ready the saved state acts in the same cycle
    assign eff    = (state_q == MEMWAIT) ? sav_q : state_q;
    assign redir  = (eff == RUN) & Redirect & IdValid & ~lu;
    assign Stall  = ~rst & (MemBusy | lu);
    assign Bubble = lu & ~MemBusy;
    assign Flush  = ~rst & ~MemBusy & (redir | (eff == FLUSH));
    // next state: memory wait beats load-use beats redirect
    always_comb begin
        state_d = eff;
        sav_d   = sav_q;
        cnt_d   = cnt_q;
        if (MemBusy) begin
            state_d = MEMWAIT;
            sav_d   = eff;
        end else if (eff == RUN && lu) begin
            state_d = LDSTALL;
        end else if (redir) begin
            cnt_d   = 2'(FLUSH_CYCLES - 1);
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (eff == LDSTALL) begin
            state_d = RUN;
        end else if (eff == FLUSH) begin
            cnt_d   = cnt_q - 2'd1;
            state_d = (cnt_q == 2'd1) ? RUN : FLUSH;
        end
    end
    // state and flush counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            sav_q   <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            sav_q   <= sav_d;
            cnt_q   <= cnt_d;
        end
    end
    // scoreboard advances ID->EX->MEM->WB except while memory is busy
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_q  <= 1'b0;
            mem_v_q <= 1'b0;
            wb_v_q  <= 1'b0;
            ex_l_q  <= 1'b0;
            ex_r_q  <= 3'd0;
            mem_r_q <= 3'd0;
            wb_r_q  <= 3'd0;
        end else if (!MemBusy) begin
            ex_v_q  <= IdValid & IdWrEn & ~Bubble;
            ex_r_q  <= IdWrReg;
            ex_l_q  <= IdIsLoad;
            mem_v_q <= ex_v_q;
            mem_r_q <= ex_r_q;
            wb_v_q  <= mem_v_q;
            wb_r_q  <= mem_r_q;
        end
    end
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] sc_q;
    // saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (rst) sc_q <= '0;
        else if (Stall && !(&sc_q)) sc_q <= sc_q + 1'b1;
    end
    assign StallCount = sc_q;
`else
    assign StallCount = '0;
`endif
endmodule
